mux16_arbiter: RTL

- Two-requester round-robin arbiter sharing one 16-bit output bus, for example a single write port into RAM or a register.
- Sequences a mux16_gate through its select line, so exactly one requester's 16-bit word drives the shared bus at a time.
- Uses a valid/ready handshake toward downstream and a one-cycle accept strobe back to each requester.
- Sits between the Week1 combinational gates and the Week3 sequential memory blocks.

---
 rtl/mux16_arbiter_pkg.sv | 23 ++
 rtl/mux16_gate.sv | 13 +
 rtl/mux16_arbiter.sv | 91 +++++++++
 3 files changed

// File: rtl/mux16_arbiter_pkg.sv
// Shared definitions for the two-requester round-robin arbiter: FSM state
// encodings and the mux select values used on the shared bus.
package mux16_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StGrantA = 2'd1,
    StGrantB = 2'd2
  } state_e;

  localparam logic SEL_A = 1'b0;
  localparam logic SEL_B = 1'b1;

  // Select value implied by a grant state; IDLE keeps whatever was selected before.
  function automatic logic grant_sel(input state_e st, input logic cur_sel);
    case (st)
      StGrantA: grant_sel = SEL_A;
      StGrantB: grant_sel = SEL_B;
      default:  grant_sel = cur_sel;
    endcase
  endfunction

endpackage

// File: rtl/mux16_gate.sv
// 16-bit 2:1 combinational multiplexer: sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux16_gate (
  input  logic [15:0] a_i,
  input  logic [15:0] b_i,
  input  logic        sel_i,
  output logic [15:0] out_o
);

  always_comb begin
    out_o = sel_i ? b_i : a_i;
  end

endmodule

// File: rtl/mux16_arbiter.sv
// Round-robin arbiter granting one of two requesters the shared 16-bit bus,
// with a valid/ready handshake downstream and one-cycle accept strobes upstream.
module mux16_arbiter
  import mux16_arbiter_pkg::*;
#(
  parameter bit RESET_PRIO = 1'b0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_a,
  input  logic [15:0] data_a,
  input  logic        req_b,
  input  logic [15:0] data_b,
  input  logic        out_ready,
  output logic [15:0] out,
  output logic        out_valid,
  output logic        ack_a,
  output logic        ack_b,
  output logic        sel
);

  state_e state_q, state_d;
  logic   prio_q, prio_d;
  logic   sel_q, sel_d;
  logic   transfer;

  mux16_gate u_mux16_gate (
    .a_i   (data_a),
    .b_i   (data_b),
    .sel_i (sel_q),
    .out_o (out)
  );

  assign sel = sel_q;

  // Handshake outputs; masked while reset is high so an aborted grant never acks.
  always_comb begin
    out_valid = ((state_q == StGrantA) && req_a) || ((state_q == StGrantB) && req_b);
    out_valid = out_valid && !reset;
    transfer  = out_valid && out_ready;
    ack_a     = transfer && (state_q == StGrantA);
    ack_b     = transfer && (state_q == StGrantB);
  end

  always_comb begin
    state_d = state_q;
    prio_d  = prio_q;
    case (state_q)
      StIdle: begin
        if (req_a && req_b) begin
          state_d = prio_q ? StGrantB : StGrantA;
        end else if (req_a) begin
          state_d = StGrantA;
        end else if (req_b) begin
          state_d = StGrantB;
        end
      end
      StGrantA: begin
        if (transfer) begin
          prio_d  = 1'b1;
          state_d = req_b ? StGrantB : StIdle;
        end else if (!req_a) begin
          state_d = StIdle;
        end
      end
      StGrantB: begin
        if (transfer) begin
          prio_d  = 1'b0;
          state_d = req_a ? StGrantA : StIdle;
        end else if (!req_b) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    sel_d = grant_sel(state_d, sel_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      prio_q  <= RESET_PRIO;
      sel_q   <= RESET_PRIO;
    end else begin
      state_q <= state_d;
      prio_q  <= prio_d;
      sel_q   <= sel_d;
    end
  end

endmodule
